// File: rtl/fifo_ser_pkg.sv
// rtl/fifo_ser_pkg.sv - shared state encoding and defaults for the FIFO word serializer
package fifo_ser_pkg;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_CNT_WIDTH  = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_LOAD  = 2'd2,
        ST_SHIFT = 2'd3
    } ser_state_e;

endpackage

// File: rtl/piso_shift_reg.sv
// rtl/piso_shift_reg.sv - parallel-load, shift-enable register presenting one serial bit
module piso_shift_reg #(
    parameter int DATA_WIDTH = 32,
    parameter bit MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  shift,
    input  logic [DATA_WIDTH-1:0] d,
    output logic                  q_bit
);

    logic [DATA_WIDTH-1:0] shreg;

    // Load wins over shift so a fresh word is never disturbed on its capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
        end else if (load) begin
            shreg <= d;
        end else if (shift) begin
            if (MSB_FIRST) begin
                shreg <= {shreg[DATA_WIDTH-2:0], 1'b0};
            end else begin
                shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
            end
        end
    end

    assign q_bit = MSB_FIRST ? shreg[DATA_WIDTH-1] : shreg[0];

endmodule

// File: rtl/fifo_word_serializer.sv
// rtl/fifo_word_serializer.sv - pops FIFO words and shifts them out over a serial valid/ready link
module fifo_word_serializer
    import fifo_ser_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter bit MSB_FIRST  = 1'b1,
    parameter int CNT_WIDTH  = DEF_CNT_WIDTH
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  EN,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    input  logic                  ser_ready,
    output logic                  ser_valid,
    output logic                  ser_bit,
    output logic                  ser_first,
    output logic                  ser_last,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  word_count
);

    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    ser_state_e    state;
    ser_state_e    state_nxt;
    logic [BW-1:0] bit_cnt;
    logic          start_ok;
    logic          accept;
    logic          word_done;
    logic          shreg_bit;

    assign start_ok  = EN && !fifo_empty;
    assign accept    = (state == ST_SHIFT) && ser_ready;
    assign word_done = accept && (bit_cnt == LAST_BIT);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // EN and fifo_empty only matter in IDLE and on the final accepted bit.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start_ok) state_nxt = ST_REQ;
            ST_REQ:   state_nxt = ST_LOAD;
            ST_LOAD:  state_nxt = ST_SHIFT;
            ST_SHIFT: if (word_done) state_nxt = start_ok ? ST_REQ : ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            bit_cnt <= '0;
        end else if (state == ST_LOAD) begin
            bit_cnt <= '0;
        end else if (accept) begin
            bit_cnt <= bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            word_count <= '0;
        end else if (word_done) begin
            word_count <= word_count + CNT_WIDTH'(1);
        end
    end

    piso_shift_reg #(
        .DATA_WIDTH (DATA_WIDTH),
        .MSB_FIRST  (MSB_FIRST)
    ) u_piso (
        .clk   (Clk),
        .rst   (Rst),
        .load  (state == ST_LOAD),
        .shift (accept),
        .d     (fifo_data),
        .q_bit (shreg_bit)
    );

    // Outputs decode registered state only, so they drop with Rst and hold while not ready.
    assign fifo_rd   = (state == ST_REQ);
    assign ser_valid = (state == ST_SHIFT);
    assign busy      = (state != ST_IDLE);
    assign ser_bit   = ser_valid && shreg_bit;
    assign ser_first = ser_valid && (bit_cnt == '0);
    assign ser_last  = ser_valid && (bit_cnt == LAST_BIT);

endmodule

// File: tb/tb_fifo_word_serializer.sv
// tb/tb_fifo_word_serializer.sv - directed self-checking bench for fifo_word_serializer
module tb_fifo_word_serializer;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        en;
    logic        fifo_empty;
    logic [31:0] fifo_data = '0;
    logic        fifo_rd;
    logic        ser_ready = 1'b1;
    logic        ser_valid, ser_bit, ser_first, ser_last, busy;
    logic [15:0] word_count;

    logic        en1, empty1, ready1, rd1, valid1, bit1, first1, last1, busy1;
    logic [31:0] data1;
    logic [15:0] wc1;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit rmode   = 1'b0;

    logic [31:0] fmem [64];
    int wp = 0;
    int rp = 0;
    int rd_empty_err = 0;

    int bidx = 0, vcnt = 0, gap_cnt = 0;
    int hold_err = 0, frame_err = 0, pulse_err = 0;
    bit counting = 1'b0, hold = 1'b0, prev_rd = 1'b0;
    logic h_bit, h_first, h_last;
    logic [31:0] rx_sh = '0;
    logic [31:0] rxq [$];
    int rdq [$];
    int firstq [$];
    int lastq [$];
    int gapq [$];

    fifo_word_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b1), .CNT_WIDTH(16)) dut (
        .Clk(Clk), .Rst(Rst), .EN(en), .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd(fifo_rd), .ser_ready(ser_ready), .ser_valid(ser_valid), .ser_bit(ser_bit),
        .ser_first(ser_first), .ser_last(ser_last), .busy(busy), .word_count(word_count)
    );

    fifo_word_serializer #(.DATA_WIDTH(32), .MSB_FIRST(1'b0), .CNT_WIDTH(16)) dut_lsb (
        .Clk(Clk), .Rst(Rst), .EN(en1), .fifo_empty(empty1), .fifo_data(data1),
        .fifo_rd(rd1), .ser_ready(ready1), .ser_valid(valid1), .ser_bit(bit1),
        .ser_first(first1), .ser_last(last1), .busy(busy1), .word_count(wc1)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    // FIFO model with one-cycle read latency
    assign fifo_empty = (wp == rp);
    always @(posedge Clk) begin
        if (fifo_rd) begin
            if (rp == wp) rd_empty_err++;
            else begin
                fifo_data <= fmem[rp[5:0]];
                rp <= rp + 1;
            end
        end
    end

    // ready pattern: constant 1, or toggling with 0 on the first bit of a word
    always @(posedge Clk) begin
        #1;
        if (rmode) ser_ready = ser_valid ? ~ser_ready : 1'b1;
        else       ser_ready = 1'b1;
    end

    // serial receiver
    always @(negedge Clk) begin
        if (Rst) begin
            bidx = 0; hold = 1'b0; prev_rd = 1'b0; counting = 1'b0;
        end else begin
            if (hold && ({ser_valid, ser_bit, ser_first, ser_last} !== {1'b1, h_bit, h_first, h_last}))
                hold_err++;
            if (ser_valid) vcnt++;
            if (fifo_rd) begin
                if (prev_rd) pulse_err++;
                rdq.push_back(cyc);
            end
            prev_rd = fifo_rd;
            if (counting) begin
                if (ser_valid) begin gapq.push_back(gap_cnt); counting = 1'b0; end
                else gap_cnt++;
            end
            if (ser_valid && ser_ready) begin
                if (ser_first !== (bidx == 0) || ser_last !== (bidx == 31)) frame_err++;
                if (bidx == 0) firstq.push_back(cyc);
                rx_sh = {rx_sh[30:0], ser_bit};
                bidx++;
                if (bidx == 32) begin
                    rxq.push_back(rx_sh);
                    lastq.push_back(cyc);
                    bidx = 0; counting = 1'b1; gap_cnt = 0;
                end
            end
            hold = ser_valid && !ser_ready;
            h_bit = ser_bit; h_first = ser_first; h_last = ser_last;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input logic [31:0] w);
        fmem[wp[5:0]] = w;
        wp = wp + 1;
    endtask

    task automatic wait_rx(input int n, input string tag);
        int t = 0;
        while (rxq.size() < n && t < 3000) begin tick(); t++; end
        check(tag, rxq.size() >= n, 1'b1);
    endtask

    task automatic wait_bidx(input int n, input string tag);
        int t = 0;
        while (bidx < n && t < 200) begin tick(); t++; end
        check(tag, bidx >= n, 1'b1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c, base, rbase, vbase, t;
        Rst = 1'b1; en = 1'b1;
        en1 = 1'b1; empty1 = 1'b1; ready1 = 1'b1; data1 = 32'h0000_0001;
        #1;
        check("rst0_outs", {fifo_rd, ser_valid, ser_bit, ser_first, ser_last, busy}, 0);
        check("rst0_cnt", word_count, 0);
        check("rst0_lsb_outs", {rd1, valid1, bit1, first1, last1, busy1}, 0);
        tick(); tick();
        Rst = 1'b0;
        tick(); tick();
        check("idle_after_rst", {busy, fifo_rd, ser_valid}, 0);

        // single word, latency and framing
        base = rxq.size(); rbase = rdq.size(); c = cyc;
        push(32'hA500_0001);
        wait_rx(base + 1, "t2_timeout");
        check("t2_word", rxq[base], 32'hA500_0001);
        check("t2_rd_count", rdq.size() - rbase, 1);
        check("t2_rd_latency", rdq[rbase], c + 1);
        check("t2_first_latency", firstq[firstq.size() - 1], c + 3);
        tick(); tick();
        check("t2_word_count", word_count, 1);
        check("t2_idle", busy, 1'b0);

        // five back-to-back words
        base = rxq.size(); rbase = rdq.size();
        for (int i = 0; i < 5; i++) push(32'(i));
        wait_rx(base + 5, "t3_timeout");
        for (int i = 0; i < 5; i++) check("t3_word", rxq[base + i], 32'(i));
        check("t3_rd_count", rdq.size() - rbase, 5);
        for (int k = 1; k <= 4; k++) check("t3_gap", gapq[gapq.size() - k], 2);
        check("t3_span", lastq[lastq.size() - 1] - rdq[rbase], 5 * 34 - 1);
        tick();
        check("t3_word_count", word_count, 6);

        // toggling ready
        rmode = 1'b1;
        base = rxq.size(); vbase = vcnt;
        push(32'hDEAD_BEEF);
        wait_rx(base + 1, "t4_timeout");
        check("t4_word", rxq[base], 32'hDEAD_BEEF);
        check("t4_shift_cycles", vcnt - vbase, 64);
        rmode = 1'b0;
        tick(); tick();
        check("t4_word_count", word_count, 7);

        // EN dropped mid-word
        base = rxq.size();
        push(32'h3); push(32'h4);
        wait_bidx(10, "t5_bit10_timeout");
        en = 1'b0;
        rbase = rdq.size();
        wait_rx(base + 1, "t5_w3_timeout");
        check("t5_word3", rxq[base], 32'h3);
        repeat (10) tick();
        check("t5_no_rd_while_off", rdq.size() - rbase, 0);
        check("t5_idle_while_off", busy, 1'b0);
        en = 1'b1; c = cyc;
        wait_rx(base + 2, "t5_w4_timeout");
        check("t5_word4", rxq[base + 1], 32'h4);
        check("t5_rd_latency", rdq[rdq.size() - 1], c + 1);
        check("t5_first_latency", firstq[firstq.size() - 1], c + 3);
        check("t5_word_count", word_count, 9);

        // reset mid-shift drops the word in flight
        base = rxq.size();
        push(32'h1111_1111); push(32'h2222_2222);
        wait_bidx(16, "t6_bit16_timeout");
        Rst = 1'b1;
        #1;
        check("t6_rst_outs", {fifo_rd, ser_valid, ser_bit, ser_first, ser_last, busy}, 0);
        check("t6_rst_cnt", word_count, 0);
        tick();
        Rst = 1'b0;
        wait_rx(base + 1, "t6_timeout");
        check("t6_next_word", rxq[base], 32'h2222_2222);
        check("t6_rx_count", rxq.size() - base, 1);
        tick();
        check("t6_word_count", word_count, 1);

        // LSB-first instance
        empty1 = 1'b0;
        t = 0;
        while (!rd1 && t < 20) begin tick(); t++; end
        check("t7_rd", rd1, 1'b1);
        empty1 = 1'b1;
        t = 0;
        while (!valid1 && t < 20) begin tick(); t++; end
        check("t7_valid", valid1, 1'b1);
        for (int i = 0; i < 32; i++) begin
            check("t7_lsb_bit", {bit1, first1, last1}, {i == 0, i == 0, i == 31});
            tick();
        end
        tick();
        check("t7_word_count", wc1, 1);
        check("t7_idle", busy1, 1'b0);

        check("rd_single_pulse", pulse_err, 0);
        check("frame_markers", frame_err, 0);
        check("hold_stable", hold_err, 0);
        check("rd_on_empty", rd_empty_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
